// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - opcodes, FSM states and datapath select encodings shared by the controllers
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_IALU) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// rtl/imm_src_decoder.sv - opcode to immediate-format select, shared with the single-cycle build
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [1:0] imm_src_o
);

  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OP_SW:   imm_src_o = IMM_S;
      OP_BEQ:  imm_src_o = IMM_B;
      OP_JAL:  imm_src_o = IMM_J;
      default: imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM sequencing the shared-ALU multi-cycle datapath
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       illegal
);

  state_e state_q, state_d;
  logic   pc_write, mem_write, ir_write, reg_write, illegal_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_write    = 1'b0;
    AdrSrc      = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    reg_write   = 1'b0;
    ALUOp       = ALUOP_ADD;
    illegal_raw = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_IALU:      state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
        illegal_raw = !op_supported(op);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        ALUSrcA  = SRCA_RS1;
        ALUOp    = ALUOP_SUB;
        pc_write = zero;
      end
      S_JAL: begin
        // ALUOut captures OldPC+4 here so ALUWB can write the link register.
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pc_write = 1'b1;
        state_d  = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are gated by reset directly so an abort cannot leak a write.
  assign PCWrite  = pc_write    & rst_n;
  assign MemWrite = mem_write   & rst_n;
  assign IRWrite  = ir_write    & rst_n;
  assign RegWrite = reg_write   & rst_n;
  assign illegal  = illegal_raw & rst_n;

  imm_src_decoder u_imm_src_decoder (
    .op_i      (op),
    .imm_src_o (ImmSrc)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for the multi-cycle control FSM
module tb_multicycle_controller;

  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
    P_EXECR, P_EXECI, P_ALUWB, P_BEQ, P_JAL
  } phase_t;

  typedef struct {
    phase_t     ph;
    logic       rdy;
    logic       z;
    logic       rst;
    logic [6:0] op;
  } entry_t;

  typedef struct {
    phase_t      ph;
    logic [15:0] vec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;

  entry_t plan[$];
  exp_t   exp_q[$];
  int     tests = 0;
  int     fails = 0;

  multicycle_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .RegWrite  (RegWrite),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Output table per step, written straight from the control behaviour description.
  function automatic logic [15:0] exp_out(input phase_t ph, input logic rdy, input logic z,
                                          input logic rst, input logic [6:0] opc);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, aop = 0, imm = 0;
    case (ph)
      P_FETCH:    begin sb = 2; rs = 2; irw = rdy; pcw = rdy; end
      P_DECODE:   begin sa = 1; sb = 1;
                        ill = !(opc == 7'h03 || opc == 7'h23 || opc == 7'h33 ||
                                opc == 7'h13 || opc == 7'h63 || opc == 7'h6f); end
      P_MEMADR:   begin sa = 2; sb = 1; end
      P_MEMREAD:  adr = 1;
      P_MEMWB:    begin rs = 1; rw = 1; end
      P_MEMWRITE: begin adr = 1; mw = 1; end
      P_EXECR:    begin sa = 2; aop = 2; end
      P_EXECI:    begin sa = 2; sb = 1; aop = 2; end
      P_ALUWB:    rw = 1;
      P_BEQ:      begin sa = 2; aop = 1; pcw = z; end
      P_JAL:      begin sa = 1; sb = 2; pcw = 1; end
      default:    ;
    endcase
    case (opc)
      7'h23:   imm = 1;
      7'h63:   imm = 2;
      7'h6f:   imm = 3;
      default: imm = 0;
    endcase
    if (!rst) begin pcw = 0; irw = 0; mw = 0; rw = 0; ill = 0; end
    return {pcw, adr, mw, irw, rs, sa, sb, rw, aop, imm, ill};
  endfunction

  task automatic push_e(input phase_t ph, input logic rdy, input logic z, input logic rst,
                        input logic [6:0] opc);
    entry_t e;
    e.ph = ph; e.rdy = rdy; e.z = z; e.rst = rst; e.op = opc;
    plan.push_back(e);
  endtask

  task automatic push_any(input phase_t ph, input logic [6:0] opc);
    push_e(ph, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, opc);
  endtask

  // One instruction: wf fetch waits, wm data-memory waits, z is the branch outcome.
  task automatic add_instr(input logic [6:0] opc, input int wf, input int wm, input logic z);
    for (int i = 0; i < wf; i++) push_e(P_FETCH, 1'b0, 1'($urandom_range(0, 1)), 1'b1, opc);
    push_e(P_FETCH, 1'b1, 1'($urandom_range(0, 1)), 1'b1, opc);
    push_any(P_DECODE, opc);
    case (opc)
      7'h03: begin
        push_any(P_MEMADR, opc);
        for (int i = 0; i < wm; i++) push_e(P_MEMREAD, 1'b0, 1'b0, 1'b1, opc);
        push_e(P_MEMREAD, 1'b1, 1'b0, 1'b1, opc);
        push_any(P_MEMWB, opc);
      end
      7'h23: begin
        push_any(P_MEMADR, opc);
        for (int i = 0; i < wm; i++) push_e(P_MEMWRITE, 1'b0, 1'b1, 1'b1, opc);
        push_e(P_MEMWRITE, 1'b1, 1'b1, 1'b1, opc);
      end
      7'h33: begin push_any(P_EXECR, opc); push_any(P_ALUWB, opc); end
      7'h13: begin push_any(P_EXECI, opc); push_any(P_ALUWB, opc); end
      7'h63: push_e(P_BEQ, 1'($urandom_range(0, 1)), z, 1'b1, opc);
      7'h6f: begin push_any(P_JAL, opc); push_any(P_ALUWB, opc); end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        s;
      logic [15:0] act;
      s   = exp_q.pop_front();
      act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             RegWrite, ALUOp, ImmSrc, illegal};
      tests++;
      if (act !== s.vec) begin
        fails++;
        $display("FAIL step_%s at %0t: got %h expected %h", s.ph.name(), $time, act, s.vec);
      end
    end
  end

  initial begin
    logic [6:0] ops[6];
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33;
    ops[3] = 7'h13; ops[4] = 7'h63; ops[5] = 7'h6f;

    push_e(P_FETCH, 1'b1, 1'b0, 1'b0, 7'h03);
    push_e(P_FETCH, 1'b1, 1'b0, 1'b0, 7'h03);
    add_instr(7'h03, 0, 0, 1'b0);
    add_instr(7'h23, 0, 2, 1'b0);
    add_instr(7'h63, 0, 0, 1'b1);
    add_instr(7'h63, 0, 0, 1'b0);
    add_instr(7'h6f, 0, 0, 1'b0);
    add_instr(7'h7f, 0, 0, 1'b0);
    add_instr(7'h33, 1, 0, 1'b0);
    add_instr(7'h13, 0, 0, 1'b0);

    push_e(P_FETCH, 1'b1, 1'b0, 1'b1, 7'h23);
    push_any(P_DECODE, 7'h23);
    push_any(P_MEMADR, 7'h23);
    push_e(P_MEMWRITE, 1'b0, 1'b0, 1'b1, 7'h23);
    push_e(P_FETCH, 1'b1, 1'b0, 1'b0, 7'h23);
    push_e(P_FETCH, 1'b0, 1'b0, 1'b0, 7'h23);
    add_instr(7'h33, 0, 0, 1'b0);

    for (int n = 0; n < 50; n++) begin
      logic [6:0] o;
      o = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
      add_instr(o, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    foreach (plan[i]) begin
      exp_t s;
      @(posedge clk);
      #1;
      rst_n     = plan[i].rst;
      mem_ready = plan[i].rdy;
      zero      = plan[i].z;
      op        = plan[i].op;
      s.ph      = plan[i].ph;
      s.vec     = exp_out(plan[i].ph, plan[i].rdy, plan[i].z, plan[i].rst, plan[i].op);
      exp_q.push_back(s);
    end
    repeat (2) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
